// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package serial_addsub_pkg;

  // Operand/result width used when the instantiating code does not override N.
  localparam int DEFAULT_N = 8;

  // Controller states: waiting, shifting bits, one-cycle completion.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/shift_reg_n.sv
// N-bit right shifter with parallel load, shift enable and serial input at
// the MSB. Load has priority over shift.
module shift_reg_n
  import serial_addsub_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         shift_en,
  input  logic         ser_in,
  output logic [N-1:0] q
);

  logic [N-1:0] q_q;
  logic [N-1:0] q_d;

  // Next-value selection: load, shift right with ser_in entering the MSB, or hold.
  always_comb begin
    // NOTE: assigning the hold value first means every path writes q_d, so no latch is inferred.
    q_d = q_q;
    if (load) begin
      q_d = load_val;
    end else if (shift_en) begin
      q_d = {ser_in, q_q[N-1:1]};
    end
  end

  // Register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state uses non-blocking assignment so every flop samples pre-edge values.
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial N-bit adder/subtractor: one bit per clock, LSB first.
// A subtraction is A + ~B + 1, done by inverting B at load time and seeding
// the carry with 1. Legal widths are 2..32.
// Optional feature: define SERIAL_ADDSUB_OVF_EN to produce the signed
// overflow flag Ovf; without it Ovf is tied to 0 and its flop is absent.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         Start,
  input  logic         Sub,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         Busy,
  output logic         Done,
  output logic [N-1:0] Sum,
  output logic         Cout,
  output logic         Ovf
);

  localparam int CW = $clog2(N + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          carry_q, carry_d;

  logic          accept;
  logic          shift_en;
  logic [N-1:0]  a_sh;
  logic [N-1:0]  b_sh;
  logic          a_bit;
  logic          b_bit;
  logic          sum_bit;
  logic          carry_nxt;

  // Only the LSBs of the operand shifters feed the adder cell.
  logic          unused_upper;
  assign unused_upper = ^{a_sh[N-1:1], b_sh[N-1:1]};

  assign a_bit     = a_sh[0];
  assign b_bit     = b_sh[0];
  assign sum_bit   = a_bit ^ b_bit ^ carry_q;
  assign carry_nxt = (a_bit & b_bit) | (a_bit & carry_q) | (b_bit & carry_q);

  // Start is honoured whenever no operation is in flight, including the DONE cycle.
  assign accept   = Start && (state_q != RUN);
  assign shift_en = (state_q == RUN);

  // Next-state, counter and carry logic for the controller.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          state_d = RUN;
          cnt_d   = CW'(N);
          carry_d = Sub;
        end
      end
      RUN: begin
        carry_d = carry_nxt;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Controller registers; reset abandons any operation in flight.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
    end
  end

  shift_reg_n #(.N(N)) u_a_sh (
    .clk      (Clock),
    .rst_n    (Reset),
    .load     (accept),
    .load_val (A),
    .shift_en (shift_en),
    .ser_in   (1'b0),
    .q        (a_sh)
  );

  shift_reg_n #(.N(N)) u_b_sh (
    .clk      (Clock),
    .rst_n    (Reset),
    .load     (accept),
    .load_val (B ^ {N{Sub}}),
    .shift_en (shift_en),
    .ser_in   (1'b0),
    .q        (b_sh)
  );

  // The result register is never loaded: N shifts replace every bit.
  shift_reg_n #(.N(N)) u_sum_sh (
    .clk      (Clock),
    .rst_n    (Reset),
    .load     (1'b0),
    .load_val ('0),
    .shift_en (shift_en),
    .ser_in   (sum_bit),
    .q        (Sum)
  );

  assign Busy = (state_q == RUN);
  assign Done = (state_q == DONE);
  // After the last bit the carry flop holds the MSB carry-out until the next accept.
  assign Cout = carry_q;

`ifdef SERIAL_ADDSUB_OVF_EN
  logic cin_msb_q, cin_msb_d;

  // Capture the carry entering the MSB while the last bit is processed.
  always_comb begin
    cin_msb_d = cin_msb_q;
    if (state_q == RUN && cnt_q == CW'(1)) begin
      cin_msb_d = carry_q;
    end
  end

  // MSB carry-in register.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      cin_msb_q <= 1'b0;
    end else begin
      cin_msb_q <= cin_msb_d;
    end
  end

  assign Ovf = cin_msb_q ^ carry_q;
`else
  assign Ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub (N=8): a word-level model checked
// every cycle, plus directed vectors with hand-computed results.
module tb_serial_addsub;

  localparam int N = 8;

`ifdef SERIAL_ADDSUB_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic         Clock = 1'b0;
  logic         Reset = 1'b0;
  logic         Start = 1'b0;
  logic         Sub   = 1'b0;
  logic [N-1:0] A     = '0;
  logic [N-1:0] B     = '0;
  logic         Busy;
  logic         Done;
  logic [N-1:0] Sum;
  logic         Cout;
  logic         Ovf;

  int n_chk = 0;
  int n_err = 0;

  serial_addsub #(.N(N)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .Start (Start),
    .Sub   (Sub),
    .A     (A),
    .B     (B),
    .Busy  (Busy),
    .Done  (Done),
    .Sum   (Sum),
    .Cout  (Cout),
    .Ovf   (Ovf)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Word-level reference: unsigned result/carry and signed-range overflow.
  function automatic void model_op(input logic sub, input logic [N-1:0] a, input logic [N-1:0] b,
                                   output logic [N-1:0] s, output logic c, output logic o);
    longint ua, ub, sa, sb, r, rs;
    ua = longint'(a);
    ub = longint'(b);
    sa = a[N-1] ? ua - (longint'(1) << N) : ua;
    sb = b[N-1] ? ub - (longint'(1) << N) : ub;
    if (sub) begin
      r  = ua - ub;
      c  = (ua >= ub);
      rs = sa - sb;
    end else begin
      r  = ua + ub;
      c  = (r >= (longint'(1) << N));
      rs = sa + sb;
    end
    s = r[N-1:0];
    o = OVF_EN && ((rs > (longint'(1) << (N - 1)) - 1) || (rs < -(longint'(1) << (N - 1))));
  endfunction

  // Model state: remaining busy cycles, done flag, published and pending results.
  int           m_cnt  = 0;
  logic         m_done = 1'b0;
  logic [N-1:0] m_sum  = '0;
  logic         m_cout = 1'b0;
  logic         m_ovf  = 1'b0;
  logic [N-1:0] p_sum;
  logic         p_cout;
  logic         p_ovf;

  always @(posedge Clock) begin
    if (Reset) begin
      if (m_cnt != 0) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin
          m_done = 1'b1;
          m_sum  = p_sum;
          m_cout = p_cout;
          m_ovf  = p_ovf;
        end
      end else begin
        m_done = 1'b0;
        if (Start) begin
          m_cnt = N;
          model_op(Sub, A, B, p_sum, p_cout, p_ovf);
        end
      end
    end
  end

  always @(negedge Reset) begin
    m_cnt  = 0;
    m_done = 1'b0;
    m_sum  = '0;
    m_cout = 1'b0;
    m_ovf  = 1'b0;
  end

  // Compare on the falling edge; results are only defined outside RUN.
  always @(negedge Clock) begin
    check("busy", 32'(Busy), 32'(m_cnt != 0));
    check("done", 32'(Done), 32'(m_done));
    if (m_cnt == 0) begin
      check("sum",  32'(Sum),  32'(m_sum));
      check("cout", 32'(Cout), 32'(m_cout));
      check("ovf",  32'(Ovf),  32'(m_ovf));
    end
  end

  // One operation from posedge+1: latency, busy length and literal results.
  task automatic run_op(input logic sub, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [N-1:0] exp_sum, input logic exp_c, input logic exp_o,
                        input int ignore_at, input string tag);
    int busy_cnt;
    int done_edge;
    busy_cnt  = 0;
    done_edge = 0;
    Sub   = sub;
    A     = a;
    B     = b;
    Start = 1'b1;
    for (int e = 1; e <= 20 && done_edge == 0; e++) begin
      @(posedge Clock);
      #1;
      if (e == 1) Start = 1'b0;
      if (ignore_at != 0 && e == ignore_at) begin
        Start = 1'b1;
        Sub   = ~sub;
        A     = 8'hAA;
        B     = 8'h55;
      end
      if (ignore_at != 0 && e == ignore_at + 1) Start = 1'b0;
      if (Busy) busy_cnt++;
      if (Done) done_edge = e;
    end
    check({tag, "_latency"}, 32'(done_edge), 32'(N + 1));
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(N));
    check({tag, "_sum"},  32'(Sum),  32'(exp_sum));
    check({tag, "_cout"}, 32'(Cout), 32'(exp_c));
    check({tag, "_ovf"},  32'(Ovf),  32'(exp_o && OVF_EN));
  endtask

  typedef struct {
    logic         sub;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] s;
    logic         c;
    logic         o;
  } vec_t;

  vec_t vecs[8];
  vec_t b2b[3];

  initial begin
    int idx;
    int done_seen;
    vecs[0] = '{1'b0, 8'h05, 8'h03, 8'h08, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};
    vecs[5] = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
    vecs[6] = '{1'b1, 8'h03, 8'h03, 8'h00, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 8'h40, 8'h40, 8'h80, 1'b0, 1'b1};
    b2b[0]  = '{1'b0, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0};
    b2b[1]  = '{1'b0, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0};
    b2b[2]  = '{1'b1, 8'h7F, 8'hFF, 8'h80, 1'b0, 1'b1};

    // Reset state.
    #2;
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_sum",  32'(Sum),  32'd0);
    check("rst_cout", 32'(Cout), 32'd0);
    check("rst_ovf",  32'(Ovf),  32'd0);
    @(posedge Clock);
    #1;
    Reset = 1'b1;

    // Directed vectors; the first Start is taken on the first edge after reset.
    foreach (vecs[i]) begin
      run_op(vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].c, vecs[i].o, 0,
             $sformatf("vec%0d", i));
    end

    // Start during RUN cycle 3 must not disturb the operation in flight.
    run_op(1'b0, 8'h05, 8'h03, 8'h08, 1'b0, 1'b0, 3, "ignore");
    @(posedge Clock);
    #1;

    // Start held high: Done every N+1 edges, operands taken at each accepting edge.
    idx   = 0;
    Sub   = b2b[0].sub;
    A     = b2b[0].a;
    B     = b2b[0].b;
    Start = 1'b1;
    for (int e = 1; e <= 3 * (N + 1) + 1; e++) begin
      @(posedge Clock);
      #1;
      if (e == 1 || e == N + 2) begin
        Sub = b2b[(e == 1) ? 1 : 2].sub;
        A   = b2b[(e == 1) ? 1 : 2].a;
        B   = b2b[(e == 1) ? 1 : 2].b;
      end
      if (e == 2 * (N + 1) + 1) Start = 1'b0;
      if (Done && idx < 3) begin
        check($sformatf("b2b%0d_edge", idx), 32'(e), 32'((idx + 1) * (N + 1)));
        check($sformatf("b2b%0d_sum", idx),  32'(Sum),  32'(b2b[idx].s));
        check($sformatf("b2b%0d_cout", idx), 32'(Cout), 32'(b2b[idx].c));
        check($sformatf("b2b%0d_ovf", idx),  32'(Ovf),  32'(b2b[idx].o && OVF_EN));
        idx++;
      end
    end
    check("b2b_count", 32'(idx), 32'd3);

    // Reset in RUN cycle 4: outputs clear at once and no Done follows.
    @(posedge Clock);
    #1;
    Sub   = 1'b0;
    A     = 8'hFF;
    B     = 8'hFF;
    Start = 1'b1;
    @(posedge Clock);
    #1;
    Start = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    Reset = 1'b0;
    #1;
    check("abort_busy", 32'(Busy), 32'd0);
    check("abort_done", 32'(Done), 32'd0);
    check("abort_sum",  32'(Sum),  32'd0);
    check("abort_cout", 32'(Cout), 32'd0);
    check("abort_ovf",  32'(Ovf),  32'd0);
    repeat (2) @(posedge Clock);
    #1;
    Reset = 1'b1;
    done_seen = 0;
    repeat (2 * N) begin
      @(posedge Clock);
      #1;
      if (Done) done_seen++;
    end
    check("abort_no_done", 32'(done_seen), 32'd0);
    run_op(1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 0, "after_abort");

    repeat (2) @(posedge Clock);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
